// File: rtl/escal_pkg.sv
// Shared types for the scalar core EX->MEM stage: branch kinds, the NZCV flag
// word and the payload carried from EX into MEM.
package escal_pkg;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int RD_W   = 4;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10,
    BR_LT   = 2'b11
  } br_type_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic              reg_we;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] store_data;
  } ex_mem_t;

endpackage

// File: rtl/escal_ex_mem_stage_if.sv
// Bundle of every EX-side and MEM-side signal of the EX->MEM stage.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid never waits on ready, and payload is held stable while
// valid & ~ready. in_ready_o is registered so it never depends on in_valid_i.
interface escal_ex_mem_stage_if;
  import escal_pkg::*;

  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] alu_result_i;
  logic              alu_cout_i;
  logic              alu_ovf_i;
  logic              alu_eq_i;
  logic              alu_blt_i;
  logic              set_flags_i;
  logic [1:0]        br_type_i;
  logic [PC_W-1:0]   pc_i;
  logic [PC_W-1:0]   br_off_i;
  logic [RD_W-1:0]   rd_i;
  logic              reg_we_i;
  logic              mem_re_i;
  logic              mem_we_i;
  logic [DATA_W-1:0] store_data_i;

  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_result_o;
  logic [RD_W-1:0]   out_rd_o;
  logic              out_reg_we_o;
  logic              out_mem_re_o;
  logic              out_mem_we_o;
  logic [DATA_W-1:0] out_store_data_o;
  logic              br_taken_o;
  logic [PC_W-1:0]   br_target_o;
  logic [3:0]        flags_o;

  // Environment side: drives EX payload and MEM ready, observes the stage.
  modport master (
    output in_valid_i, alu_result_i, alu_cout_i, alu_ovf_i, alu_eq_i, alu_blt_i,
           set_flags_i, br_type_i, pc_i, br_off_i, rd_i, reg_we_i, mem_re_i,
           mem_we_i, store_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_result_o, out_rd_o, out_reg_we_o,
           out_mem_re_o, out_mem_we_o, out_store_data_o, br_taken_o,
           br_target_o, flags_o
  );

  // Stage side.
  modport slave (
    input  in_valid_i, alu_result_i, alu_cout_i, alu_ovf_i, alu_eq_i, alu_blt_i,
           set_flags_i, br_type_i, pc_i, br_off_i, rd_i, reg_we_i, mem_re_i,
           mem_we_i, store_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_result_o, out_rd_o, out_reg_we_o,
           out_mem_re_o, out_mem_we_o, out_store_data_o, br_taken_o,
           br_target_o, flags_o
  );
endinterface

// File: rtl/escal_skid_buffer.sv
// Generic 2-entry skid buffer: an output register plus one skid register.
// in_ready is just ~skid_valid, so it is registered and never combinational
// on either side's handshake, while still sustaining one transfer per cycle.
module escal_skid_buffer #(
  parameter type T = escal_pkg::ex_mem_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic skid_valid;
  T     skid_data;
  logic accept;
  logic fire;

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready & ~flush;
  assign fire     = out_valid & out_ready;

  // Move entries: skid drains into output first, new ops land in output when
  // it is free (or leaving this cycle), otherwise they park in the skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (fire) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid || fire) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end else if (fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/escal_ex_mem_stage.sv
// EX->MEM pipeline stage: buffers the ALU result and memory controls through a
// skid buffer, resolves conditional branches at accept and owns NZCV.
module escal_ex_mem_stage
  import escal_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  escal_ex_mem_stage_if.slave  bus
);

  logic      accept;
  logic      taken;
  br_type_e  br_type;
  ex_mem_t   in_pkt;
  ex_mem_t   out_pkt;
  flags_t    flags_q;
  logic      br_taken_q;
  logic [PC_W-1:0] br_target_q;

  assign accept  = bus.in_valid_i & bus.in_ready_o & ~flush_i;
  assign br_type = br_type_e'(bus.br_type_i);

  assign in_pkt.result     = bus.alu_result_i;
  assign in_pkt.rd         = bus.rd_i;
  assign in_pkt.reg_we     = bus.reg_we_i;
  assign in_pkt.mem_re     = bus.mem_re_i;
  assign in_pkt.mem_we     = bus.mem_we_i;
  assign in_pkt.store_data = bus.store_data_i;

  escal_skid_buffer #(.T(ex_mem_t)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_i),
    .in_valid  (bus.in_valid_i),
    .in_ready  (bus.in_ready_o),
    .in_data   (in_pkt),
    .out_valid (bus.out_valid_o),
    .out_ready (bus.out_ready_i),
    .out_data  (out_pkt)
  );

  assign bus.out_result_o     = out_pkt.result;
  assign bus.out_rd_o         = out_pkt.rd;
  assign bus.out_reg_we_o     = out_pkt.reg_we;
  assign bus.out_mem_re_o     = out_pkt.mem_re;
  assign bus.out_mem_we_o     = out_pkt.mem_we;
  assign bus.out_store_data_o = out_pkt.store_data;

  // Branch condition from the ALU compare outputs.
  always_comb begin
    taken = 1'b0;
    unique case (br_type)
      BR_EQ:   taken = bus.alu_eq_i;
      BR_NE:   taken = ~bus.alu_eq_i;
      BR_LT:   taken = bus.alu_blt_i;
      default: taken = 1'b0;
    endcase
  end

  // Redirect pulse one cycle after a taken branch is accepted; MEM backpressure
  // does not delay it. Target holds its last value between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      br_taken_q <= accept & taken;
      if (accept && taken) begin
        br_target_q <= bus.pc_i + bus.br_off_i;
      end
    end
  end

  // Architectural NZCV, written only by accepted flag-setting ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (accept && bus.set_flags_i) begin
      flags_q.n <= bus.alu_result_i[DATA_W-1];
      flags_q.z <= (bus.alu_result_i == '0);
      flags_q.c <= bus.alu_cout_i;
      flags_q.v <= bus.alu_ovf_i;
    end
  end

  assign bus.br_taken_o  = br_taken_q;
  assign bus.br_target_o = br_target_q;
  assign bus.flags_o     = flags_q;

endmodule

// File: tb/tb_escal_ex_mem_stage.sv
// Directed bench for the EX->MEM stage with an expected-payload queue.
module tb_escal_ex_mem_stage;
  import escal_pkg::*;

  localparam int PKT_W = $bits(ex_mem_t);

  logic clk;
  logic rst_n;
  logic flush_i;

  escal_ex_mem_stage_if bus();

  escal_ex_mem_stage dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [PKT_W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [DATA_W-1:0] res);
    bus.alu_result_i = res;
    bus.rd_i         = RD_W'($urandom_range(0, 15));
    bus.reg_we_i     = 1'($urandom_range(0, 1));
    bus.mem_re_i     = 1'($urandom_range(0, 1));
    bus.mem_we_i     = 1'($urandom_range(0, 1));
    bus.store_data_i = $urandom();
    bus.set_flags_i  = 1'b0;
    bus.br_type_i    = 2'b00;
    bus.alu_eq_i     = 1'b0;
    bus.alu_blt_i    = 1'b0;
    bus.alu_cout_i   = 1'b0;
    bus.alu_ovf_i    = 1'b0;
    bus.pc_i         = $urandom();
    bus.br_off_i     = $urandom();
  endtask

  function automatic logic [PKT_W-1:0] in_pkt();
    ex_mem_t p;
    p.result     = bus.alu_result_i;
    p.rd         = bus.rd_i;
    p.reg_we     = bus.reg_we_i;
    p.mem_re     = bus.mem_re_i;
    p.mem_we     = bus.mem_we_i;
    p.store_data = bus.store_data_i;
    return p;
  endfunction

  function automatic logic [PKT_W-1:0] out_pkt();
    ex_mem_t p;
    p.result     = bus.out_result_o;
    p.rd         = bus.out_rd_o;
    p.reg_we     = bus.out_reg_we_o;
    p.mem_re     = bus.out_mem_re_o;
    p.mem_we     = bus.out_mem_we_o;
    p.store_data = bus.out_store_data_o;
    return p;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 128'(bus.out_valid_o), 128'(1'b0));
    check({tag, "_in_ready"},  128'(bus.in_ready_o),  128'(1'b1));
    check({tag, "_br_taken"},  128'(bus.br_taken_o),  128'(1'b0));
    check({tag, "_br_target"}, 128'(bus.br_target_o), 128'(0));
    check({tag, "_flags"},     128'(bus.flags_o),     128'(0));
    check({tag, "_out_data"},  128'(out_pkt()),       128'(0));
  endtask

  // ---------------- scoreboard ----------------
  // Inputs change only just after rising edges, so the falling edge sees the
  // values that the next rising edge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid_o && bus.out_ready_i) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL sb_unexpected: observed %0h expected none", out_pkt());
        end
        if (exp_q.size() > 0) begin
          logic [PKT_W-1:0] exp;
          exp = exp_q.pop_front();
          check("sb_data", 128'(out_pkt()), 128'(exp));
        end
      end
      if (flush_i) exp_q.delete();
      else if (bus.in_valid_i && bus.in_ready_o) exp_q.push_back(in_pkt());
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [DATA_W-1:0] res_a;
    logic [DATA_W-1:0] res_b;
    rst_n = 1'b0;
    flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    set_op('0);
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Streaming at full throughput, one-cycle latency.
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_op($urandom());
      bus.in_valid_i = 1'b1;
      check("stream_in_ready", 128'(bus.in_ready_o), 128'(1'b1));
      res_a = bus.alu_result_i;
      tick();
      check("stream_out_valid", 128'(bus.out_valid_o), 128'(1'b1));
      check("stream_latency", 128'(bus.out_result_o), 128'(res_a));
    end
    bus.in_valid_i = 1'b0;
    tick();
    check("stream_drained", 128'(bus.out_valid_o), 128'(1'b0));

    // Backpressure: two ops held, third refused, then drained in order.
    bus.out_ready_i = 1'b0;
    set_op(32'hAAAA_0001); res_a = bus.alu_result_i;
    bus.in_valid_i = 1'b1;
    tick();
    check("stall_in_ready_1", 128'(bus.in_ready_o), 128'(1'b1));
    set_op(32'hBBBB_0002); res_b = bus.alu_result_i;
    tick();
    check("stall_in_ready_2", 128'(bus.in_ready_o), 128'(1'b0));
    check("stall_hold_a", 128'(bus.out_result_o), 128'(res_a));
    set_op(32'hCCCC_0003);
    tick();
    check("stall_in_ready_3", 128'(bus.in_ready_o), 128'(1'b0));
    check("stall_valid", 128'(bus.out_valid_o), 128'(1'b1));
    check("stall_stable_a", 128'(bus.out_result_o), 128'(res_a));
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    tick();
    check("drain_b", 128'(bus.out_result_o), 128'(res_b));
    check("drain_in_ready", 128'(bus.in_ready_o), 128'(1'b1));
    tick();
    check("drain_empty", 128'(bus.out_valid_o), 128'(1'b0));

    // Branches: beq taken with wrapping target, bne not taken, blt taken.
    set_op(32'h0);
    bus.br_type_i = 2'b01; bus.alu_eq_i = 1'b1;
    bus.pc_i = 32'h100; bus.br_off_i = 32'hFFFF_FFF0;
    bus.in_valid_i = 1'b1;
    tick();
    check("beq_taken", 128'(bus.br_taken_o), 128'(1'b1));
    check("beq_target", 128'(bus.br_target_o), 128'(32'h0F0));
    bus.in_valid_i = 1'b0;
    tick();
    check("beq_one_cycle", 128'(bus.br_taken_o), 128'(1'b0));
    set_op(32'h0);
    bus.br_type_i = 2'b10; bus.alu_eq_i = 1'b1;
    bus.in_valid_i = 1'b1;
    tick();
    check("bne_not_taken", 128'(bus.br_taken_o), 128'(1'b0));
    set_op(32'h0);
    bus.br_type_i = 2'b11; bus.alu_blt_i = 1'b1;
    bus.pc_i = 32'hFFFF_FFF8; bus.br_off_i = 32'h10;
    tick();
    check("blt_taken", 128'(bus.br_taken_o), 128'(1'b1));
    check("blt_target_wrap", 128'(bus.br_target_o), 128'(32'h8));

    // Flags.
    set_op(32'h8000_0000);
    bus.set_flags_i = 1'b1; bus.alu_cout_i = 1'b1; bus.alu_ovf_i = 1'b1;
    tick();
    check("flags_nxcv", 128'(bus.flags_o), 128'(4'b1011));
    set_op(32'h0);
    bus.set_flags_i = 1'b1;
    tick();
    check("flags_zero", 128'(bus.flags_o), 128'(4'b0100));
    set_op(32'h8000_0005);
    bus.alu_cout_i = 1'b1;
    tick();
    check("flags_hold", 128'(bus.flags_o), 128'(4'b0100));
    bus.in_valid_i = 1'b0;
    tick();

    // Flush with both entries held and a flag-setting taken branch presented.
    bus.out_ready_i = 1'b0;
    set_op($urandom()); bus.in_valid_i = 1'b1;
    tick();
    set_op($urandom());
    tick();
    check("pre_flush_full", 128'(bus.in_ready_o), 128'(1'b0));
    set_op(32'h8000_0000);
    bus.set_flags_i = 1'b1; bus.alu_cout_i = 1'b1;
    bus.br_type_i = 2'b01; bus.alu_eq_i = 1'b1;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    check("flush_out_valid", 128'(bus.out_valid_o), 128'(1'b0));
    check("flush_in_ready", 128'(bus.in_ready_o), 128'(1'b1));
    check("flush_flags", 128'(bus.flags_o), 128'(4'b0100));
    check("flush_no_branch", 128'(bus.br_taken_o), 128'(1'b0));
    tick();

    // Asynchronous reset while stalled with the skid entry full.
    set_op($urandom()); bus.in_valid_i = 1'b1;
    tick();
    set_op($urandom());
    bus.br_type_i = 2'b01; bus.alu_eq_i = 1'b1;
    bus.set_flags_i = 1'b1; bus.alu_cout_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    check("pre_reset_taken", 128'(bus.br_taken_o), 128'(1'b1));
    check("pre_reset_full", 128'(bus.in_ready_o), 128'(1'b0));
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    tick();
    tick();
    check("sb_empty_at_end", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
